rfi_flagger: RTL and testbench
==============================

RFI_FLAGGER -- requirements
Module: rfi_flagger

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 16: width of the unsigned correlation-power input.
REQ-002 SHALL have parameter CHANNEL_ADDR, default 9: log2 of the number of channels per frame.
REQ-003 SHALL have parameter CNT_WIDTH, default 8: width of the per-channel consecutive-hit counter.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port din, input, DIN_WIDTH bits: unsigned correlation power, one channel per valid.
REQ-007 SHALL have port din_valid, input, 1 bit: din qualifier.
REQ-008 SHALL have port sync_in, input, 1 bit: when high together with din_valid, the sample is channel 0 of a frame.
REQ-009 SHALL have port threshold, input, DIN_WIDTH bits: software power threshold.
REQ-010 SHALL have port hit_len, input, CNT_WIDTH bits: consecutive frames above threshold required to flag.
REQ-011 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port flag, output, 1 bit: per-channel RFI flag.
REQ-013 SHALL have port flag_channel, output, CHANNEL_ADDR bits: channel index of flag.
REQ-014 SHALL have port flag_valid, output, 1 bit: flag/flag_channel qualifier.
REQ-015 SHALL have port frame_count, output, CHANNEL_ADDR+1 bits: number of flagged channels in the last frame.
REQ-016 SHALL have port frame_max, output, DIN_WIDTH bits: maximum din in the last frame.
REQ-017 SHALL have port frame_max_ch, output, CHANNEL_ADDR bits: channel of frame_max.
REQ-018 SHALL have port frame_valid, output, 1 bit: one-cycle pulse qualifying the frame_* outputs.
REQ-019 SHALL have port warning, output, 1 bit: sticky sync-misalignment indicator.

Function
REQ-020 SHALL implement FSM states CLEAR, WAIT_SYNC and RUN.
- CLEAR: writes 0 to all 2**CHANNEL_ADDR hit-counter RAM entries, one per cycle, then goes to WAIT_SYNC.
- WAIT_SYNC: ignores input until din_valid&sync_in, then enters RUN and processes that sample as channel 0.
REQ-021 SHALL keep a channel counter: set to 0 on din_valid&sync_in, else incremented on din_valid, wrapping at 2**CHANNEL_ADDR-1 -> 0.
REQ-022 SHALL, in RUN, perform a read-modify-write per valid on the RAM entry for the channel:
- din > threshold (strict): cnt_new = cnt+1, saturating at 2**CNT_WIDTH-1.
- otherwise: cnt_new = 0.
REQ-023 SHALL set flag = (cnt_new >= max(hit_len,1)); hit_len = 0 behaves as 1.
REQ-024 SHALL assert flag_valid exactly 2 cycles after the accepted din_valid, with matching flag_channel; this is a fixed latency with no backpressure.
REQ-025 SHALL accept back-to-back valids every cycle; no RAM hazard exists for CHANNEL_ADDR >= 2.
REQ-026 SHALL track per frame: the flagged-channel count, and the maximum din with its channel; on ties the first (lowest) channel is kept.
REQ-027 SHALL pulse frame_valid in the same cycle as the flag_valid of channel 2**CHANNEL_ADDR-1, with frame_* holding that frame's result until the next pulse; the accumulators restart for the next frame.
REQ-028 SHALL, on din_valid&sync_in in RUN with channel counter != 0, set warning (sticky until rst), realign to channel 0, and discard the partial frame (no frame_valid for it).
REQ-029 SHALL sample threshold and hit_len live each valid; a mid-frame change affects subsequent channels only.
REQ-030 SHALL treat din_valid low as a stall: no state change and no output pulse.

Reset
REQ-031 SHALL, on rst, enter CLEAR with clear address 0 and set channel counter=0, ready=0, flag=0, flag_channel=0, flag_valid=0, frame_count=0, frame_max=0, frame_max_ch=0, frame_valid=0, warning=0.
REQ-032 SHALL, on rst asserted mid-frame or mid-clear, abort the operation, drop in-flight results (no flag_valid after rst), and restart the full clear.

Verification (CHANNEL_ADDR=2, DIN_WIDTH=16, CNT_WIDTH=8)
REQ-033 SHALL verify clear: rst 1 cycle -> ready=0 for the 4 clear cycles plus WAIT_SYNC; first sync_in&din_valid -> ready=1 and flag_valid 2 cycles later with flag_channel=0.
REQ-034 SHALL verify hit counting: threshold=100, hit_len=3, channel 1 din=200 for 3 frames and others din=50 -> channel 1 flag=0,0,1; frame 3 gives frame_count=1, frame_max=200, frame_max_ch=1.
REQ-035 SHALL verify boundary and reset of count: din=100 equal to threshold -> flag=0 and the counter clears, so a flagged channel unflags next frame; hit_len=0 with din=101 -> flag=1 on the first frame.
REQ-036 SHALL verify saturation and ties: 300 frames above threshold with hit_len=255 -> flag stays 1 and does not wrap; din=500 on channels 2 and 3 -> frame_max_ch=2.
REQ-037 SHALL verify misalignment: sync_in at channel 2 -> warning=1 and stays 1, no frame_valid for the partial frame, and the next full frame reports correctly.
REQ-038 SHALL verify reset mid-frame: rst during channel 1 -> no flag_valid afterwards, and counters re-cleared (a previously flagged channel needs hit_len frames again).

Source files
------------

// File: rtl/rfi_flagger.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rfi_flagger
// Purpose  : Per-channel RFI flagging from consecutive above-threshold frames,
//            with per-frame flagged count and peak-power statistics.
// Revision : 1.0 - initial release
// ============================================================================
module rfi_flagger #(
    parameter int DIN_WIDTH    = 16,
    parameter int CHANNEL_ADDR = 9,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIN_WIDTH-1:0]    din,
    input  logic                    din_valid,
    input  logic                    sync_in,
    input  logic [DIN_WIDTH-1:0]    threshold,
    input  logic [CNT_WIDTH-1:0]    hit_len,
    output logic                    ready,
    output logic                    flag,
    output logic [CHANNEL_ADDR-1:0] flag_channel,
    output logic                    flag_valid,
    output logic [CHANNEL_ADDR:0]   frame_count,
    output logic [DIN_WIDTH-1:0]    frame_max,
    output logic [CHANNEL_ADDR-1:0] frame_max_ch,
    output logic                    frame_valid,
    output logic                    warning
);

    localparam int                    c_DEPTH    = 2**CHANNEL_ADDR;
    localparam logic [CHANNEL_ADDR-1:0] c_LAST_CH = '1;
    localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX  = '1;
    localparam logic [1:0]            c_S_CLEAR  = 2'd0;
    localparam logic [1:0]            c_S_WAIT   = 2'd1;
    localparam logic [1:0]            c_S_RUN    = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [CHANNEL_ADDR-1:0] r_clr_addr;
    logic [CHANNEL_ADDR-1:0] r_ch_cnt;

    logic                    w_accept;
    logic [CHANNEL_ADDR-1:0] w_ch;

    logic                    r_s1_valid;
    logic [CHANNEL_ADDR-1:0] r_s1_ch;
    logic                    r_s1_above;
    logic [DIN_WIDTH-1:0]    r_s1_din;
    logic [CNT_WIDTH-1:0]    r_s1_hit_len;
    logic [CNT_WIDTH-1:0]    r_rd_cnt;

    logic [CNT_WIDTH-1:0]    w_cnt_new;
    logic [CNT_WIDTH-1:0]    w_hit_eff;
    logic                    w_flag;
    logic [CHANNEL_ADDR:0]   w_flag_ext;
    logic                    w_new_max;

    logic                    w_ram_we;
    logic [CHANNEL_ADDR-1:0] w_ram_waddr;
    logic [CNT_WIDTH-1:0]    w_ram_wdata;
    logic [CNT_WIDTH-1:0]    r_ram [c_DEPTH];

    logic [CHANNEL_ADDR:0]   r_acc_count;
    logic [DIN_WIDTH-1:0]    r_acc_max;
    logic [CHANNEL_ADDR-1:0] r_acc_max_ch;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_CLEAR: if (r_clr_addr == c_LAST_CH) w_state_next = c_S_WAIT;
            c_S_WAIT:  if (din_valid && sync_in) w_state_next = c_S_RUN;
            c_S_RUN:   w_state_next = c_S_RUN;
            default:   w_state_next = c_S_CLEAR;
        endcase
    end

    assign ready    = (r_state == c_S_RUN);
    assign w_accept = din_valid && ((r_state == c_S_RUN) || ((r_state == c_S_WAIT) && sync_in));
    assign w_ch     = sync_in ? '0 : r_ch_cnt;

    always_comb begin
        w_cnt_new = '0;
        if (r_s1_above) begin
            w_cnt_new = (r_rd_cnt == c_CNT_MAX) ? r_rd_cnt : r_rd_cnt + CNT_WIDTH'(1);
        end
    end

    assign w_hit_eff  = (r_s1_hit_len == '0) ? CNT_WIDTH'(1) : r_s1_hit_len;
    assign w_flag     = (w_cnt_new >= w_hit_eff);
    assign w_flag_ext = {{CHANNEL_ADDR{1'b0}}, w_flag};
    assign w_new_max  = (r_s1_din > r_acc_max);

    assign w_ram_we    = !rst && ((r_state == c_S_CLEAR) || r_s1_valid);
    assign w_ram_waddr = (r_state == c_S_CLEAR) ? r_clr_addr : r_s1_ch;
    assign w_ram_wdata = (r_state == c_S_CLEAR) ? '0 : w_cnt_new;

    // A realigning sync right after channel 0 re-reads the entry being
    // written this cycle, so the fresh count is forwarded.
    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[w_ram_waddr] <= w_ram_wdata;
        if (w_accept) begin
            r_rd_cnt <= (r_s1_valid && (r_s1_ch == w_ch)) ? w_cnt_new : r_ram[w_ch];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_CLEAR;
            r_clr_addr   <= '0;
            r_ch_cnt     <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_ch      <= '0;
            r_s1_above   <= 1'b0;
            r_s1_din     <= '0;
            r_s1_hit_len <= '0;
            r_acc_count  <= '0;
            r_acc_max    <= '0;
            r_acc_max_ch <= '0;
            flag         <= 1'b0;
            flag_channel <= '0;
            flag_valid   <= 1'b0;
            frame_count  <= '0;
            frame_max    <= '0;
            frame_max_ch <= '0;
            frame_valid  <= 1'b0;
            warning      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_S_CLEAR) r_clr_addr <= r_clr_addr + CHANNEL_ADDR'(1);

            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_ch_cnt     <= w_ch + CHANNEL_ADDR'(1);
                r_s1_ch      <= w_ch;
                r_s1_above   <= (din > threshold);
                r_s1_din     <= din;
                r_s1_hit_len <= hit_len;
                if ((r_state == c_S_RUN) && sync_in && (r_ch_cnt != '0)) warning <= 1'b1;
            end

            flag_valid  <= r_s1_valid;
            frame_valid <= 1'b0;
            if (r_s1_valid) begin
                flag         <= w_flag;
                flag_channel <= r_s1_ch;
                // Channel 0 restarts the accumulators, which also drops any
                // partial frame cut short by a realigning sync.
                if (r_s1_ch == '0) begin
                    r_acc_count  <= w_flag_ext;
                    r_acc_max    <= r_s1_din;
                    r_acc_max_ch <= '0;
                end else begin
                    r_acc_count <= r_acc_count + w_flag_ext;
                    if (w_new_max) begin
                        r_acc_max    <= r_s1_din;
                        r_acc_max_ch <= r_s1_ch;
                    end
                end
                if (r_s1_ch == c_LAST_CH) begin
                    frame_valid  <= 1'b1;
                    frame_count  <= r_acc_count + w_flag_ext;
                    frame_max    <= w_new_max ? r_s1_din : r_acc_max;
                    frame_max_ch <= w_new_max ? r_s1_ch : r_acc_max_ch;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rfi_flagger.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rfi_flagger
// Purpose  : Directed self-checking bench for rfi_flagger (4 channels/frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rfi_flagger;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        sync_in = 1'b0;
    logic [15:0] threshold = 16'd100;
    logic [7:0]  hit_len = 8'd3;
    logic        ready;
    logic        flag;
    logic [1:0]  flag_channel;
    logic        flag_valid;
    logic [2:0]  frame_count;
    logic [15:0] frame_max;
    logic [1:0]  frame_max_ch;
    logic        frame_valid;
    logic        warning;

    int n_checks = 0;
    int n_errors = 0;

    logic mon_flag [4];
    int   mon_fv_n = 0;
    int   mon_fr_n = 0;

    rfi_flagger #(.DIN_WIDTH(16), .CHANNEL_ADDR(2), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync_in(sync_in),
        .threshold(threshold), .hit_len(hit_len), .ready(ready), .flag(flag),
        .flag_channel(flag_channel), .flag_valid(flag_valid), .frame_count(frame_count),
        .frame_max(frame_max), .frame_max_ch(frame_max_ch), .frame_valid(frame_valid),
        .warning(warning)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (flag_valid) begin
            mon_flag[flag_channel] <= flag;
            mon_fv_n <= mon_fv_n + 1;
        end
        if (frame_valid) mon_fr_n <= mon_fr_n + 1;
    end

    task automatic cycle_in(input logic v, input logic s, input logic [15:0] d);
        din_valid = v;
        sync_in   = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3, input int idle);
        cycle_in(1'b1, 1'b1, d0);
        cycle_in(1'b1, 1'b0, d1);
        cycle_in(1'b1, 1'b0, d2);
        cycle_in(1'b1, 1'b0, d3);
        for (int i = 0; i < idle; i++) cycle_in(1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cycle_in(1'b0, 1'b0, 16'd0);
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %0d expected 0", ready); end
        n_checks++; if (flag_valid !== 1'b0) begin n_errors++; $display("FAIL reset_flag_valid: got %0d expected 0", flag_valid); end
        n_checks++; if (flag !== 1'b0 || flag_channel !== 2'd0) begin n_errors++; $display("FAIL reset_flag: got %0d/%0d expected 0/0", flag, flag_channel); end
        n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL reset_frame_valid: got %0d expected 0", frame_valid); end
        n_checks++; if (frame_count !== 3'd0 || frame_max !== 16'd0 || frame_max_ch !== 2'd0) begin
            n_errors++; $display("FAIL reset_frame: got %0d/%0d/%0d expected 0/0/0", frame_count, frame_max, frame_max_ch); end
        n_checks++; if (warning !== 1'b0) begin n_errors++; $display("FAIL reset_warning: got %0d expected 0", warning); end
        rst = 1'b0;
    endtask

    task automatic test_clear;
        for (int i = 0; i < 6; i++) begin
            cycle_in(1'b1, 1'b0, 16'd500);
            n_checks++; if (ready !== 1'b0 || flag_valid !== 1'b0) begin
                n_errors++; $display("FAIL clear_idle[%0d]: got ready=%0d fv=%0d expected 0/0", i, ready, flag_valid); end
        end
        cycle_in(1'b1, 1'b1, 16'd0);
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL clear_ready: got %0d expected 1", ready); end
        n_checks++; if (flag_valid !== 1'b0) begin n_errors++; $display("FAIL clear_latency1: got fv=%0d expected 0", flag_valid); end
        cycle_in(1'b1, 1'b0, 16'd0);
        n_checks++; if (flag_valid !== 1'b1 || flag_channel !== 2'd0 || flag !== 1'b0) begin
            n_errors++; $display("FAIL clear_latency2: got fv=%0d ch=%0d flag=%0d expected 1/0/0", flag_valid, flag_channel, flag); end
        cycle_in(1'b1, 1'b0, 16'd0);
        cycle_in(1'b1, 1'b0, 16'd0);
        cycle_in(1'b0, 1'b0, 16'd0);
        cycle_in(1'b0, 1'b0, 16'd0);
        n_checks++; if (mon_fr_n !== 1) begin n_errors++; $display("FAIL clear_first_frame: got %0d frames expected 1", mon_fr_n); end
    endtask

    task automatic test_hit_count;
        int fv0, fr0;
        threshold = 16'd100; hit_len = 8'd3;
        fv0 = mon_fv_n; fr0 = mon_fr_n;
        for (int f = 1; f <= 3; f++) begin
            send_frame(16'd50, 16'd200, 16'd50, 16'd50, 2);
            n_checks++; if (mon_flag[1] !== (f == 3)) begin
                n_errors++; $display("FAIL hit_flag_f%0d: got %0d expected %0d", f, mon_flag[1], (f == 3)); end
        end
        n_checks++; if (frame_count !== 3'd1 || frame_max !== 16'd200 || frame_max_ch !== 2'd1) begin
            n_errors++; $display("FAIL hit_frame: got %0d/%0d/%0d expected 1/200/1", frame_count, frame_max, frame_max_ch); end
        n_checks++; if (mon_fv_n - fv0 !== 12 || mon_fr_n - fr0 !== 3) begin
            n_errors++; $display("FAIL hit_pulses: got fv=%0d fr=%0d expected 12/3", mon_fv_n - fv0, mon_fr_n - fr0); end
    endtask

    task automatic test_boundary;
        send_frame(16'd50, 16'd100, 16'd50, 16'd50, 2);
        n_checks++; if (mon_flag[1] !== 1'b0) begin n_errors++; $display("FAIL equal_thr_flag: got %0d expected 0", mon_flag[1]); end
        n_checks++; if (frame_count !== 3'd0 || frame_max !== 16'd100 || frame_max_ch !== 2'd1) begin
            n_errors++; $display("FAIL equal_thr_frame: got %0d/%0d/%0d expected 0/100/1", frame_count, frame_max, frame_max_ch); end
        send_frame(16'd50, 16'd200, 16'd50, 16'd50, 2);
        n_checks++; if (mon_flag[1] !== 1'b0) begin n_errors++; $display("FAIL cnt_cleared: got %0d expected 0", mon_flag[1]); end
        hit_len = 8'd0;
        send_frame(16'd50, 16'd50, 16'd101, 16'd50, 2);
        n_checks++; if (mon_flag[2] !== 1'b1 || mon_flag[1] !== 1'b0) begin
            n_errors++; $display("FAIL hit_len0: got ch2=%0d ch1=%0d expected 1/0", mon_flag[2], mon_flag[1]); end
        n_checks++; if (frame_count !== 3'd1 || frame_max !== 16'd101 || frame_max_ch !== 2'd2) begin
            n_errors++; $display("FAIL hit_len0_frame: got %0d/%0d/%0d expected 1/101/2", frame_count, frame_max, frame_max_ch); end
    endtask

    // Back-to-back frames; channel 0's flag is already reported when each frame ends.
    task automatic test_saturation;
        hit_len = 8'd255;
        for (int k = 1; k <= 300; k++) begin
            send_frame(16'd150, 16'd150, 16'd500, 16'd500, (k == 300) ? 2 : 0);
            if (k == 254 || k == 255 || k == 256 || k == 300) begin
                n_checks++; if (mon_flag[0] !== (k >= 255)) begin
                    n_errors++; $display("FAIL sat_flag_f%0d: got %0d expected %0d", k, mon_flag[0], (k >= 255)); end
            end
        end
        n_checks++; if (frame_count !== 3'd4 || frame_max !== 16'd500 || frame_max_ch !== 2'd2) begin
            n_errors++; $display("FAIL sat_tie_frame: got %0d/%0d/%0d expected 4/500/2", frame_count, frame_max, frame_max_ch); end
    endtask

    task automatic test_misalign;
        int fr0;
        hit_len = 8'd3;
        fr0 = mon_fr_n;
        cycle_in(1'b1, 1'b1, 16'd50);
        cycle_in(1'b1, 1'b0, 16'd50);
        cycle_in(1'b0, 1'b0, 16'd0);
        cycle_in(1'b0, 1'b0, 16'd0);
        n_checks++; if (warning !== 1'b0) begin n_errors++; $display("FAIL warn_before: got %0d expected 0", warning); end
        send_frame(16'd500, 16'd60, 16'd300, 16'd80, 2);
        n_checks++; if (warning !== 1'b1) begin n_errors++; $display("FAIL warn_set: got %0d expected 1", warning); end
        n_checks++; if (mon_fr_n - fr0 !== 1) begin n_errors++; $display("FAIL partial_dropped: got %0d frames expected 1", mon_fr_n - fr0); end
        n_checks++; if (frame_count !== 3'd1 || frame_max !== 16'd500 || frame_max_ch !== 2'd0 || mon_flag[2] !== 1'b1) begin
            n_errors++; $display("FAIL realign_frame: got %0d/%0d/%0d f2=%0d expected 1/500/0 f2=1", frame_count, frame_max, frame_max_ch, mon_flag[2]); end
        send_frame(16'd50, 16'd50, 16'd50, 16'd50, 2);
        n_checks++; if (warning !== 1'b1 || frame_count !== 3'd0 || frame_max !== 16'd50 || frame_max_ch !== 2'd0) begin
            n_errors++; $display("FAIL warn_sticky: got w=%0d %0d/%0d/%0d expected 1 0/50/0", warning, frame_count, frame_max, frame_max_ch); end
    endtask

    // Stall cycles between samples and a threshold change after channel 1.
    task automatic test_live_params;
        int fv0, fr0;
        threshold = 16'd100; hit_len = 8'd1;
        fv0 = mon_fv_n; fr0 = mon_fr_n;
        cycle_in(1'b1, 1'b1, 16'd150);
        cycle_in(1'b0, 1'b0, 16'd0);
        cycle_in(1'b1, 1'b0, 16'd150);
        threshold = 16'd200;
        cycle_in(1'b0, 1'b0, 16'd0);
        cycle_in(1'b1, 1'b0, 16'd150);
        cycle_in(1'b1, 1'b0, 16'd250);
        cycle_in(1'b0, 1'b0, 16'd0);
        cycle_in(1'b0, 1'b0, 16'd0);
        n_checks++; if (mon_flag[0] !== 1'b1 || mon_flag[1] !== 1'b1 || mon_flag[2] !== 1'b0 || mon_flag[3] !== 1'b1) begin
            n_errors++; $display("FAIL live_flags: got %0d%0d%0d%0d expected 1101", mon_flag[0], mon_flag[1], mon_flag[2], mon_flag[3]); end
        n_checks++; if (mon_fv_n - fv0 !== 4 || mon_fr_n - fr0 !== 1) begin
            n_errors++; $display("FAIL stall_pulses: got fv=%0d fr=%0d expected 4/1", mon_fv_n - fv0, mon_fr_n - fr0); end
        n_checks++; if (frame_count !== 3'd3 || frame_max !== 16'd250 || frame_max_ch !== 2'd3) begin
            n_errors++; $display("FAIL live_frame: got %0d/%0d/%0d expected 3/250/3", frame_count, frame_max, frame_max_ch); end
        threshold = 16'd100;
    endtask

    task automatic test_reset_midframe;
        int fv0;
        hit_len = 8'd2;
        send_frame(16'd50, 16'd200, 16'd50, 16'd50, 2);
        n_checks++; if (mon_flag[1] !== 1'b1) begin n_errors++; $display("FAIL pre_rst_flag: got %0d expected 1", mon_flag[1]); end
        fv0 = mon_fv_n;
        cycle_in(1'b1, 1'b1, 16'd50);
        rst = 1'b1;
        cycle_in(1'b1, 1'b0, 16'd200);
        rst = 1'b0;
        n_checks++; if (ready !== 1'b0 || warning !== 1'b0 || frame_max !== 16'd0 || frame_count !== 3'd0) begin
            n_errors++; $display("FAIL rst_mid_state: got rdy=%0d w=%0d max=%0d cnt=%0d expected 0/0/0/0", ready, warning, frame_max, frame_count); end
        for (int i = 0; i < 8; i++) cycle_in(1'b0, 1'b0, 16'd0);
        n_checks++; if (mon_fv_n !== fv0) begin n_errors++; $display("FAIL rst_inflight: got %0d flag_valids expected 0", mon_fv_n - fv0); end
        send_frame(16'd50, 16'd200, 16'd50, 16'd50, 2);
        n_checks++; if (mon_flag[1] !== 1'b0) begin n_errors++; $display("FAIL rst_recount1: got %0d expected 0", mon_flag[1]); end
        send_frame(16'd50, 16'd200, 16'd50, 16'd50, 2);
        n_checks++; if (mon_flag[1] !== 1'b1) begin n_errors++; $display("FAIL rst_recount2: got %0d expected 1", mon_flag[1]); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset;
        test_clear;
        test_hit_count;
        test_boundary;
        test_saturation;
        test_misalign;
        test_live_params;
        test_reset_midframe;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
